// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall, bubble and flush sequencing for the 5-stage core
module hazard_stall_controller #(
    parameter int REG_W       = 3,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             src1_used,
    input  logic             src2_used,
    input  logic [REG_W-1:0] dest_EX,
    input  logic             wb_IDEX_out,
    input  logic             mem_read_EX,
    input  logic             mul_ID,
    input  logic             branch_taken_EX,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_write_en,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN,
        MUL_WAIT
    } state_t;

    localparam logic [3:0]       MUL_CNT_INIT = 4'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t     state, state_nxt;
    logic [3:0] mul_cnt, mul_cnt_nxt;
    logic       load_use;
    logic       mul_issue;

    assign load_use = mem_read_EX & wb_IDEX_out &
                      ((src1_used & (src1_ID == dest_EX)) |
                       (src2_used & (src2_ID == dest_EX)));
    assign mul_issue = mul_ID & ~load_use & ~branch_taken_EX;

    always_comb begin
        state_nxt     = state;
        mul_cnt_nxt   = mul_cnt;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_write_en = 1'b1;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        mul_busy      = 1'b0;
        case (state)
            RUN: begin
                // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
                if (branch_taken_EX) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                end else if (mul_issue) begin
                    state_nxt   = MUL_WAIT;
                    mul_cnt_nxt = MUL_CNT_INIT;
                end
            end
            MUL_WAIT: begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_write_en = 1'b0;
                exmem_bubble  = 1'b1;
                mul_busy      = 1'b1;
                mul_cnt_nxt   = mul_cnt - 4'd1;
                // The final occupancy cycle runs in RUN so the result can advance to MEM.
                if (mul_cnt <= 4'd1) begin
                    state_nxt   = RUN;
                    mul_cnt_nxt = 4'd0;
                end
            end
            default: begin
                state_nxt   = RUN;
                mul_cnt_nxt = 4'd0;
            end
        endcase
        if (!rst_n) begin
            pc_write_en   = 1'b1;
            ifid_write_en = 1'b1;
            ifid_flush    = 1'b0;
            idex_write_en = 1'b1;
            idex_bubble   = 1'b0;
            exmem_bubble  = 1'b0;
            mul_busy      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!pc_write_en && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  src1_ID, src2_ID, dest_EX;
    logic        src1_used, src2_used, wb_IDEX_out, mem_read_EX, mul_ID, branch_taken_EX;
    logic        pc_write_en, ifid_write_en, ifid_flush, idex_write_en;
    logic        idex_bubble, exmem_bubble, mul_busy;
    logic [15:0] stall_count;
    logic        s_pc, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_bubble, s_exmem_bubble, s_mul_busy;
    logic [3:0]  s_stall_count;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_W(3), .MUL_LATENCY(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .src1_used(src1_used), .src2_used(src2_used),
        .dest_EX(dest_EX), .wb_IDEX_out(wb_IDEX_out), .mem_read_EX(mem_read_EX),
        .mul_ID(mul_ID), .branch_taken_EX(branch_taken_EX),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
        .idex_write_en(idex_write_en), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .mul_busy(mul_busy), .stall_count(stall_count)
    );

    hazard_stall_controller #(.REG_W(3), .MUL_LATENCY(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .src1_ID(src1_ID), .src2_ID(src2_ID), .src1_used(src1_used), .src2_used(src2_used),
        .dest_EX(dest_EX), .wb_IDEX_out(wb_IDEX_out), .mem_read_EX(mem_read_EX),
        .mul_ID(mul_ID), .branch_taken_EX(branch_taken_EX),
        .pc_write_en(s_pc), .ifid_write_en(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_write_en(s_idex_we), .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
        .mul_busy(s_mul_busy), .stall_count(s_stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src1_ID = 3'd0; src2_ID = 3'd0; dest_EX = 3'd0;
        src1_used = 1'b0; src2_used = 1'b0; wb_IDEX_out = 1'b0;
        mem_read_EX = 1'b0; mul_ID = 1'b0; branch_taken_EX = 1'b0;
    endtask

    task automatic load_use_src2();
        mem_read_EX = 1'b1; wb_IDEX_out = 1'b1; dest_EX = 3'd3;
        src2_ID = 3'd3; src2_used = 1'b1;
    endtask

    // Advance to 1 ns after the next rising edge, then settle inputs before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check("rst_pc", pc_write_en, 1);
        check("rst_idex_we", idex_write_en, 1);
        check("rst_bubbles", {ifid_flush, idex_bubble, exmem_bubble, mul_busy}, 0);
        check("rst_cnt", stall_count, 0);
        step();
        rst_n = 1'b1;

        // Load-use on src2
        load_use_src2();
        #2;
        check("lu_pc", pc_write_en, 0);
        check("lu_ifid_we", ifid_write_en, 0);
        check("lu_bubble", idex_bubble, 1);
        check("lu_idex_we", idex_write_en, 1);
        step();
        idle();
        #2;
        check("lu_cnt", stall_count, 1);
        check("lu_after_en", {pc_write_en, ifid_write_en, idex_write_en, idex_bubble}, 4'b1110);

        // Matching but unused src2
        load_use_src2();
        src2_used = 1'b0; src1_ID = 3'd5; src1_used = 1'b1;
        #2;
        check("unused_pc", pc_write_en, 1);
        check("unused_bubble", idex_bubble, 0);
        step();
        idle();
        check("unused_cnt", stall_count, 1);

        // Branch takes priority over load-use
        load_use_src2();
        branch_taken_EX = 1'b1;
        #2;
        check("br_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_pc", pc_write_en, 1);
        step();
        idle();
        check("br_cnt", stall_count, 1);

        // Multiply, latency 3: two MUL_WAIT cycles; branch ignored while waiting
        mul_ID = 1'b1;
        #2;
        check("mul_issue_pc", pc_write_en, 1);
        check("mul_issue_busy", mul_busy, 0);
        step();
        mul_ID = 1'b0;
        #2;
        check("mul_w1", {pc_write_en, idex_write_en, exmem_bubble, mul_busy}, 4'b0011);
        step();
        branch_taken_EX = 1'b1;
        #2;
        check("mul_w2", {pc_write_en, idex_write_en, exmem_bubble, mul_busy}, 4'b0011);
        check("mul_w2_noflush", ifid_flush, 0);
        step();
        branch_taken_EX = 1'b0;
        #2;
        check("mul_done", {pc_write_en, idex_write_en, exmem_bubble, mul_busy}, 4'b1100);
        check("mul_cnt", stall_count, 3);

        // Multiply behind a load-use hazard
        load_use_src2();
        mul_ID = 1'b1;
        #2;
        check("lumul_bubble", {pc_write_en, idex_bubble, mul_busy}, 3'b010);
        step();
        mem_read_EX = 1'b0;
        #2;
        check("lumul_issue", {pc_write_en, idex_bubble, mul_busy}, 3'b100);
        step();
        idle();
        check("lumul_w1", mul_busy, 1);
        step();
        check("lumul_w2", mul_busy, 1);
        step();
        check("lumul_done", mul_busy, 0);
        check("lumul_cnt", stall_count, 6);

        // Asynchronous reset during the first MUL_WAIT cycle
        mul_ID = 1'b1;
        step();
        mul_ID = 1'b0;
        check("arst_pre_busy", mul_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", mul_busy, 0);
        check("arst_en", {pc_write_en, ifid_write_en, idex_write_en, exmem_bubble}, 4'b1110);
        check("arst_cnt", stall_count, 0);
        step();
        rst_n = 1'b1;

        // Twenty consecutive load-use cycles saturate the 4-bit counter
        load_use_src2();
        for (int i = 0; i < 20; i++) step();
        idle();
        check("sat_cnt4", s_stall_count, 15);
        check("sat_cnt16", stall_count, 20);
        step();
        check("sat_hold", s_stall_count, 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
